// File: rtl/gate_chk_pkg.sv
// rtl/gate_chk_pkg.sv - shared types and constants for the gate vector checker
//
// Purpose: sweep-controller state encoding, settle-counter width and the
//          standard 2-input truth tables (bit i = expected y for vector i,
//          with vector bit 0 on input a and bit 1 on input b).
// Ports:   none (package).
package gate_chk_pkg;

   localparam int SETTLE_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_chk_settle_cnt.sv
// rtl/gate_chk_settle_cnt.sv - settle-time counter for the gate vector checker
//
// Purpose: 4-bit up-counter that measures how long the current vector has
//          been held; terminal marks the cycle on which dut_y is sampled.
// Ports:   clk        - clock, rising edge
//          rst        - synchronous active-high reset
//          clr_i      - clear the count to 0 (wins over en_i)
//          en_i       - count up by one
//          terminal_o - count equals SETTLE
module gate_chk_settle_cnt
   import gate_chk_pkg::*;
#(
   parameter logic [SETTLE_W-1:0] SETTLE = 4'd2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic terminal_o
);

   logic [SETTLE_W-1:0] count_q;
   logic [SETTLE_W-1:0] count_d;

   // The controller clears on terminal, so the count never passes SETTLE
   // and cannot wrap.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign terminal_o = (count_q == SETTLE);

endmodule

// File: rtl/gate_vector_checker.sv
// rtl/gate_vector_checker.sv - exhaustive stimulus/response checker for one-output gates
//
// Purpose: on start, drives every input vector 0..2^N_IN-1 to the gate under
//          test, holds each for SETTLE+1 cycles, samples dut_y on the last
//          cycle and compares it with TRUTH. Reports pass, error count and
//          the lowest failing vector.
// Ports:   clk        - clock, rising edge
//          rst        - synchronous active-high reset
//          start      - request a sweep (only looked at in IDLE)
//          vec_out    - stimulus; bit 0 = input a, bit 1 = input b
//          dut_y      - gate under test output
//          busy       - sweep in progress
//          done       - one-cycle pulse at sweep end
//          pass       - last sweep had no mismatches (valid from done)
//          err_count  - number of mismatching vectors
//          first_fail - lowest failing vector, 0 if none
//          fail_seen  - at least one mismatch in the last sweep
//          fail_map   - per-vector mismatch bits (only with GATE_CHK_FAIL_MAP_EN)
// Config:  define GATE_CHK_FAIL_MAP_EN to add the fail_map port and register.
module gate_vector_checker
   import gate_chk_pkg::*;
#(
   parameter int                    N_IN   = 2,
   parameter int                    SETTLE = 2,
   parameter logic [(1<<N_IN)-1:0]  TRUTH  = 4'b0111
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [N_IN-1:0]      vec_out,
   input  logic                 dut_y,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [N_IN:0]        err_count,
   output logic [N_IN-1:0]      first_fail,
`ifdef GATE_CHK_FAIL_MAP_EN
   output logic [(1<<N_IN)-1:0] fail_map,
`endif
   output logic                 fail_seen
);

   localparam int              N_VEC    = 1 << N_IN;
   localparam logic [N_IN-1:0] LAST_VEC = N_IN'(N_VEC - 1);

   state_e state_q, state_d;

   logic [N_IN-1:0] vec_q, vec_d;
   logic [N_IN:0]   err_q, err_d;
   logic [N_IN-1:0] first_q, first_d;
   logic            fail_seen_q, fail_seen_d;
   logic            pass_q, pass_d;
`ifdef GATE_CHK_FAIL_MAP_EN
   logic [N_VEC-1:0] map_q, map_d;
`endif

   logic accept;
   logic terminal;
   logic sample;
   logic exp_y;
   logic mismatch;

   gate_chk_settle_cnt #(
      .SETTLE (SETTLE_W'(SETTLE))
   ) u_settle_cnt (
      .clk        (clk),
      .rst        (rst),
      .clr_i      ((state_q != DRIVE) || terminal),
      .en_i       (state_q == DRIVE),
      .terminal_o (terminal)
   );

   assign accept = (state_q == IDLE) && start;
   assign sample = (state_q == DRIVE) && terminal;
   assign exp_y  = TRUTH[vec_q];

   // Written as "assume mismatch unless provably equal" so an X/Z on dut_y
   // falls through the if and is scored as a failure in simulation.
   always_comb begin
      mismatch = 1'b1;
      if (dut_y == exp_y) begin
         mismatch = 1'b0;
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = DRIVE;
         DRIVE:   if (sample && (vec_q == LAST_VEC)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy = (state_q == DRIVE);
      done = (state_q == DONE);
   end

   // ---------------- result datapath ----------------
   always_comb begin
      vec_d       = vec_q;
      err_d       = err_q;
      first_d     = first_q;
      fail_seen_d = fail_seen_q;
      pass_d      = pass_q;
`ifdef GATE_CHK_FAIL_MAP_EN
      map_d       = map_q;
`endif
      if (accept) begin
         // Results of the previous sweep stay visible until here.
         vec_d       = '0;
         err_d       = '0;
         first_d     = '0;
         fail_seen_d = 1'b0;
         pass_d      = 1'b0;
`ifdef GATE_CHK_FAIL_MAP_EN
         map_d       = '0;
`endif
      end else if (sample) begin
         if (mismatch) begin
            err_d = err_q + 1'b1;
            if (!fail_seen_q) begin
               first_d     = vec_q;
               fail_seen_d = 1'b1;
            end
`ifdef GATE_CHK_FAIL_MAP_EN
            map_d[vec_q] = 1'b1;
`endif
         end
         if (vec_q == LAST_VEC) begin
            // pass is registered on entry to DONE so it is already valid
            // while done is high.
            vec_d  = '0;
            pass_d = (err_d == '0);
         end else begin
            vec_d = vec_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vec_q       <= '0;
         err_q       <= '0;
         first_q     <= '0;
         fail_seen_q <= 1'b0;
         pass_q      <= 1'b0;
`ifdef GATE_CHK_FAIL_MAP_EN
         map_q       <= '0;
`endif
      end else begin
         vec_q       <= vec_d;
         err_q       <= err_d;
         first_q     <= first_d;
         fail_seen_q <= fail_seen_d;
         pass_q      <= pass_d;
`ifdef GATE_CHK_FAIL_MAP_EN
         map_q       <= map_d;
`endif
      end
   end

   assign vec_out    = vec_q;
   assign err_count  = err_q;
   assign first_fail = first_q;
   assign fail_seen  = fail_seen_q;
   assign pass       = pass_q;
`ifdef GATE_CHK_FAIL_MAP_EN
   assign fail_map   = map_q;
`endif

endmodule

// File: tb/tb_gate_vector_checker.sv
// tb/tb_gate_vector_checker.sv - scoreboard bench for gate_vector_checker
module tb_gate_vector_checker;
   import gate_chk_pkg::*;

   typedef struct packed {
      logic       pass;
      logic [2:0] err;
      logic [1:0] first;
      logic       seen;
      logic [3:0] map;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       start0 = 1'b0;
   logic [2:0] gate_sel = 3'd0;

   logic [1:0] vec_out, vec_out0;
   logic       dut_y, dut_y0;
   logic       busy, done, pass, fail_seen;
   logic       busy0, done0, pass0, fail_seen0;
   logic [2:0] err_count, err_count0;
   logic [1:0] first_fail, first_fail0;
`ifdef GATE_CHK_FAIL_MAP_EN
   logic [3:0] fail_map, fail_map0;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   exp_t sb[$];
   exp_t sb0[$];

   always #5 clk = ~clk;

   // Gate under test models: 0 NAND, 1 AND, 2 tied 0, 3 tied 1, 4 OR
   always_comb begin
      case (gate_sel)
         3'd0:    dut_y = ~(vec_out[0] & vec_out[1]);
         3'd1:    dut_y = vec_out[0] & vec_out[1];
         3'd2:    dut_y = 1'b0;
         3'd3:    dut_y = 1'b1;
         3'd4:    dut_y = vec_out[0] | vec_out[1];
         default: dut_y = 1'b0;
      endcase
   end
   assign dut_y0 = ~(vec_out0[0] & vec_out0[1]);

   gate_vector_checker #(.N_IN(2), .SETTLE(2), .TRUTH(TT_NAND)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .vec_out    (vec_out),
      .dut_y      (dut_y),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_count  (err_count),
      .first_fail (first_fail),
`ifdef GATE_CHK_FAIL_MAP_EN
      .fail_map   (fail_map),
`endif
      .fail_seen  (fail_seen)
   );

   gate_vector_checker #(.N_IN(2), .SETTLE(0), .TRUTH(TT_NAND)) u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .start      (start0),
      .vec_out    (vec_out0),
      .dut_y      (dut_y0),
      .busy       (busy0),
      .done       (done0),
      .pass       (pass0),
      .err_count  (err_count0),
      .first_fail (first_fail0),
`ifdef GATE_CHK_FAIL_MAP_EN
      .fail_map   (fail_map0),
`endif
      .fail_seen  (fail_seen0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors: compare results whenever a done pulse is presented.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", done, 1'b0);
            end else begin
               e = sb.pop_front();
               chk("pass", pass, e.pass);
               chk("err_count", err_count, e.err);
               chk("first_fail", first_fail, e.first);
               chk("fail_seen", fail_seen, e.seen);
               chk("busy_at_done", busy, 1'b0);
`ifdef GATE_CHK_FAIL_MAP_EN
               chk("fail_map", fail_map, e.map);
`endif
            end
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done0) begin
            if (sb0.size() == 0) begin
               chk("unexpected_done0", done0, 1'b0);
            end else begin
               e = sb0.pop_front();
               chk("pass0", pass0, e.pass);
               chk("err_count0", err_count0, e.err);
               chk("fail_seen0", fail_seen0, e.seen);
            end
         end
      end
   end

   task automatic run_sweep(input logic [2:0] sel, input exp_t e);
      int cyc;
      @(negedge clk);
      gate_sel = sel;
      start    = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (busy && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      chk("busy_cycles", cyc, 12);
      chk("done_after_busy", done, 1'b1);
      @(negedge clk);
      chk("err_hold", err_count, e.err);
      chk("pass_hold", pass, e.pass);
   endtask

   initial begin
      int cyc;
      logic seen_done;

      repeat (3) @(negedge clk);
      chk("rst_vec_out", vec_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_first_fail", first_fail, 0);
      chk("rst_fail_seen", fail_seen, 0);
      rst = 1'b0;

      // correct NAND, AND gate, tied 0, tied 1, OR gate
      run_sweep(3'd0, '{pass: 1'b1, err: 3'd0, first: 2'd0, seen: 1'b0, map: 4'b0000});
      run_sweep(3'd1, '{pass: 1'b0, err: 3'd4, first: 2'd0, seen: 1'b1, map: 4'b1111});
      run_sweep(3'd2, '{pass: 1'b0, err: 3'd3, first: 2'd0, seen: 1'b1, map: 4'b0111});
      run_sweep(3'd3, '{pass: 1'b0, err: 3'd1, first: 2'd3, seen: 1'b1, map: 4'b1000});
      run_sweep(3'd4, '{pass: 1'b0, err: 3'd2, first: 2'd0, seen: 1'b1, map: 4'b1001});

      // SETTLE=0: one cycle per vector, done at E0+5
      @(negedge clk);
      start0 = 1'b1;
      sb0.push_back('{pass: 1'b1, err: 3'd0, first: 2'd0, seen: 1'b0, map: 4'b0000});
      @(negedge clk);
      start0 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("s0_vec_out", vec_out0, i);
         chk("s0_busy", busy0, 1'b1);
         @(negedge clk);
      end
      chk("s0_done", done0, 1'b1);

      // Reset in the 5th busy cycle of a failing sweep
      @(negedge clk);
      gate_sel = 3'd1;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_rst_busy", busy, 1'b1);
      chk("pre_rst_err", err_count, 1);
      chk("pre_rst_vec", vec_out, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_vec_out", vec_out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_pass", pass, 0);
      chk("mid_rst_err_count", err_count, 0);
      chk("mid_rst_first_fail", first_fail, 0);
      chk("mid_rst_fail_seen", fail_seen, 0);
`ifdef GATE_CHK_FAIL_MAP_EN
      chk("mid_rst_fail_map", fail_map, 0);
`endif
      seen_done = 1'b0;
      repeat (20) begin
         if (done || busy) seen_done = 1'b1;
         @(negedge clk);
      end
      chk("no_done_after_rst", seen_done, 1'b0);
      run_sweep(3'd0, '{pass: 1'b1, err: 3'd0, first: 2'd0, seen: 1'b0, map: 4'b0000});

      // start held high: back-to-back sweeps, one DONE and one IDLE cycle apart
      @(negedge clk);
      gate_sel = 3'd0;
      start    = 1'b1;
      sb.push_back('{pass: 1'b1, err: 3'd0, first: 2'd0, seen: 1'b0, map: 4'b0000});
      sb.push_back('{pass: 1'b1, err: 3'd0, first: 2'd0, seen: 1'b0, map: 4'b0000});
      @(negedge clk);
      cyc = 0;
      while (busy && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      chk("held_busy_cycles_1", cyc, 12);
      chk("held_done_1", done, 1'b1);
      @(negedge clk);
      chk("held_idle_busy", busy, 1'b0);
      chk("held_idle_done", done, 1'b0);
      chk("held_idle_pass", pass, 1'b1);
      @(negedge clk);
      cyc = 0;
      while (busy && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      chk("held_busy_cycles_2", cyc, 12);
      chk("held_done_2", done, 1'b1);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("held_stop_busy", busy, 1'b0);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      chk("sb0_drained", sb0.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/gate_vector_checker.md
# gate_vector_checker

Self-checking stimulus/response stage for single-output combinational gates. Sweeps every input combination into a gate under test (upstream role), samples the gate's output after a programmable settle time (downstream role), and compares it with a parameterised truth table. Reports pass/fail, an error count and the first failing vector, giving the basic-gates library an RTL-side checker usable in simulation and on hardware.

## Interface
- N_IN, 2: number of gate inputs; 1–4 supported.
- SETTLE, 2: extra cycles each vector is held before sampling; 0–15.
- TRUTH, 4'b0111: expected output per vector; bit i is the expected y for vector i. The default is 2-input NAND.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request a sweep; sampled only in IDLE.
- vec_out  out  N_IN  stimulus to the gate under test; bit 0 drives input a, bit 1 drives input b.
- dut_y  in  1  output of the gate under test.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- pass  out  1  result of the last sweep; valid from done until the next start.
- err_count  out  N_IN+1  number of mismatching vectors.
- first_fail  out  N_IN  lowest failing vector; 0 if none.
- fail_seen  out  1  at least one mismatch in the last sweep.

## Operation
- States are IDLE, DRIVE and DONE.
- **IDLE:**
  - When start=1, go to DRIVE.
  - Clear vec_out, the settle counter, err_count, first_fail, fail_seen and pass.
- **DRIVE:**
  - Hold vec_out and increment the counter from 0 to SETTLE.
  - On the edge where counter==SETTLE, compare dut_y with TRUTH[vec_out].
  - On a mismatch, increment err_count. If fail_seen=0, also capture first_fail=vec_out and set fail_seen.
  - If vec_out is the last vector (2^N_IN−1), go to DONE. Otherwise increment vec_out and clear the counter.
- **DONE:**
  - For one cycle: done=1, and pass=(err_count==0) is registered.
  - Then return to IDLE.
- vec_out is driven to 0 in IDLE and DONE.
- Results hold until the next accepted start.
- start is ignored in DRIVE and DONE. If start is held high continuously, a new sweep is accepted on the first IDLE cycle.
- dut_y containing X/Z counts as a mismatch in simulation.
- err_count saturates naturally: the maximum is 2^N_IN, which fits in N_IN+1 bits.

## Timing
- Reset values: vec_out=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, fail_seen=0, state=IDLE.
- start is sampled at edge E0. DRIVE and busy=1 begin at E0+1, and vector 0 appears on vec_out in the same cycle.
- Each vector is held for SETTLE+1 cycles. dut_y is sampled on the last edge of that window.
- A sweep occupies 2^N_IN·(SETTLE+1) busy cycles. done is asserted in the following cycle, with busy=0. With the defaults, done is high in cycle E0+13.
- rst=1 at any point, including mid-sweep, returns every output to its reset value on the next edge. No done pulse is produced.
- SETTLE=0 is legal: one cycle per vector.

## Configuration
- Macro: GATE_CHK_FAIL_MAP_EN.
- **Defined:**
  - Adds output port fail_map [2^N_IN−1:0], reset to 0 and cleared on accepted start.
  - Bit i is set when vector i mismatches.
- **Undefined:**
  - The port and register are absent.
  - All other behaviour is identical.

## Structure
- Package gate_chk_pkg holds:
  - the state enum (IDLE, DRIVE, DONE);
  - 2-input truth-table constants: TT_AND=4'b1000, TT_NAND=4'b0111, TT_OR=4'b1110, TT_NOR=4'b0001, TT_XOR=4'b0110, TT_XNOR=4'b1001;
  - the SETTLE width constant (4 bits).
- One sub-module, gate_chk_settle_cnt:
  - a 4-bit up-counter with clear and enable;
  - outputs terminal=(count==SETTLE).

## Test plan
- Defaults, connected to a correct 2-input NAND, start pulsed once → busy for 12 cycles, then done. Expected result: pass=1, err_count=0, fail_seen=0.
- TRUTH=TT_NAND, connected to an AND gate → err_count=4, pass=0, first_fail=0. With the macro defined, fail_map=4'b1111.
- TRUTH=TT_NAND, dut_y tied to 0 → err_count=3, first_fail=0. With the macro defined, fail_map=4'b0111.
- SETTLE=0, correct NAND → vec_out steps 0,1,2,3 on consecutive cycles, and done is high in cycle E0+5.
- rst asserted in the 5th busy cycle → next cycle all outputs are 0 and no done pulse. A subsequent start runs a full clean sweep.
- start held high continuously with a correct NAND → back-to-back sweeps separated by exactly one DONE cycle and one IDLE cycle. start is ignored while busy; pass=1 after each sweep.
